// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: drives a word-addressed data memory with byte lanes, extends load data, stalls the core.
// Define LSU_TIMEOUT_EN to add a watchdog that aborts an ACCESS after TIMEOUT_CYCLES wait cycles.
module lsu_mem_ctrl #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          req_ready,
    output logic          stall,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_we;
    logic        r_signed;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;

    logic          w_misaligned;
    logic [3:0]    w_be;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_shifted;
    logic [DW-1:0] w_load;

    // Lane logic is written for a 32-bit bus; catch a bad build early.
    if (DW != 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("lsu_mem_ctrl: DW must be 32 and TIMEOUT_CYCLES >= 1");
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] r_cnt;
`endif

    assign req_ready = (r_state == IDLE);
    assign stall     = ((r_state == IDLE) && req_valid) || (r_state == ACCESS);

    always_comb begin
        w_misaligned = 1'b0;
        w_be         = 4'b0000;
        w_wdata      = req_wdata;
        case (req_size)
            2'b00: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_misaligned = req_addr[0];
                w_be         = 4'b0011 << req_addr[1:0];
                w_wdata      = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                w_misaligned = |req_addr[1:0];
                w_be         = 4'b1111;
            end
            default: w_misaligned = 1'b1;
        endcase
    end

    // Selected lane lands in the low bits; halves are always 16-bit aligned here.
    assign w_shifted = mem_rdata >> {r_lane, 3'b000};

    always_comb begin
        case (r_size)
            2'b00:   w_load = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_signed   <= 1'b0;
            r_size     <= 2'b00;
            r_lane     <= 2'b00;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'b0000;
            mem_addr   <= '0;
            mem_wdata  <= '0;
`ifdef LSU_TIMEOUT_EN
            r_cnt      <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_signed <= req_signed;
                        r_size   <= req_size;
                        r_lane   <= req_addr[1:0];
                        if (w_misaligned) begin
                            r_state    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            r_state   <= ACCESS;
                            mem_en    <= 1'b1;
                            mem_we    <= req_we;
                            mem_be    <= w_be;
                            mem_addr  <= {req_addr[AW-1:2], 2'b00};
                            mem_wdata <= w_wdata;
`ifdef LSU_TIMEOUT_EN
                            r_cnt     <= '0;
`endif
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        r_state    <= RESP;
                        mem_en     <= 1'b0;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= r_we ? '0 : w_load;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (r_cnt == CNT_LAST) begin
                        r_state    <= RESP;
                        mem_en     <= 1'b0;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
`endif
                end
                RESP: begin
                    r_state    <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
